mlp_train_sequencer: RTL and testbench

//   Sequences training and inference passes of the MLP over an on-chip sample store.

---
 rtl/mlp_train_sequencer.sv | 141 ++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_train_sequencer.sv
// Sequences inference/training passes of an MLP over a small on-chip sample store.
// One sample at a time: apply, wait for the datapath to settle, capture, optionally train.
module mlp_train_sequencer #(
  parameter int unsigned INPUTS        = 2,
  parameter int unsigned OUTPUTS       = 1,
  parameter int unsigned NUM_SAMPLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned EPOCH_W       = 16,
  parameter int unsigned DATA_W        = 16,
  localparam int unsigned SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int unsigned VW = INPUTS * DATA_W,
  localparam int unsigned XW = OUTPUTS * DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SW-1:0]      wr_addr,
  input  logic [VW-1:0]      wr_values,
  input  logic [XW-1:0]      wr_expected,
  input  logic               start,
  input  logic               train_mode,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic               abort,
  input  logic [XW-1:0]      mlp_pred,
  output logic [VW-1:0]      mlp_values,
  output logic [XW-1:0]      mlp_expected,
  output logic               mlp_training,
  output logic               pred_valid,
  output logic [XW-1:0]      pred_data,
  output logic [SW-1:0]      pred_idx,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LastIdx = SW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] LastSettle = CW'(SETTLE_CYCLES - 1);
  localparam logic [EPOCH_W-1:0] EpochMax = '1;

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StUpdate, StAdvance} state_e;

  state_e             state;
  logic [SW-1:0]      idx;
  logic [CW-1:0]      settle_cnt;
  logic               train_q;
  logic [EPOCH_W-1:0] epochs_q;
  logic [EPOCH_W-1:0] epoch_inc;

  logic [VW-1:0] store_values   [NUM_SAMPLES];
  logic [XW-1:0] store_expected [NUM_SAMPLES];

  assign busy      = (state != StIdle);
  assign epoch_inc = (epoch_count == EpochMax) ? epoch_count : epoch_count + 1'b1;

  // Store has no reset; the host must reload it after reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (32'(wr_addr) < NUM_SAMPLES)) begin
      store_values[wr_addr]   <= wr_values;
      store_expected[wr_addr] <= wr_expected;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      idx          <= '0;
      settle_cnt   <= '0;
      train_q      <= 1'b0;
      epochs_q     <= '0;
      epoch_count  <= '0;
      mlp_values   <= '0;
      mlp_expected <= '0;
      mlp_training <= 1'b0;
      pred_valid   <= 1'b0;
      pred_data    <= '0;
      pred_idx     <= '0;
      done         <= 1'b0;
    end else begin
      pred_valid   <= 1'b0;
      done         <= 1'b0;
      mlp_training <= 1'b0;
      if (abort) begin
        state <= StIdle;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              train_q     <= train_mode;
              epochs_q    <= num_epochs;
              idx         <= '0;
              epoch_count <= '0;
              if (num_epochs == '0) done  <= 1'b1;
              else                  state <= StApply;
            end
          end
          StApply: begin
            mlp_values   <= store_values[idx];
            mlp_expected <= store_expected[idx];
            settle_cnt   <= '0;
            state        <= StSettle;
          end
          StSettle: begin
            if (settle_cnt == LastSettle) begin
              pred_data  <= mlp_pred;
              pred_idx   <= idx;
              pred_valid <= 1'b1;
              // Training strobe is raised on entry so it is high exactly while in UPDATE.
              if (train_q) begin
                mlp_training <= 1'b1;
                state        <= StUpdate;
              end else begin
                state <= StAdvance;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          StUpdate: state <= StAdvance;
          StAdvance: begin
            if (idx == LastIdx) begin
              idx         <= '0;
              epoch_count <= epoch_inc;
              if (epoch_inc == epochs_q) begin
                done  <= 1'b1;
                state <= StIdle;
              end else begin
                state <= StApply;
              end
            end else begin
              idx   <= idx + 1'b1;
              state <= StApply;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Randomised self-checking bench for mlp_train_sequencer; two instances (4- and 3-deep stores)
// share all host inputs so an out-of-range write address can be exercised on the smaller one.
`timescale 1ns/1ps
module tb_mlp_train_sequencer;
  localparam int NA = 4;
  localparam int NB = 3;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_en = 1'b0, start = 1'b0, train_mode = 1'b0, abort = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_values = '0, num_epochs = '0;
  logic [7:0]  wr_expected = '0;

  logic [15:0] va, vb, eca, ecb;
  logic [7:0]  xa, xb, preda, predb, pda, pdb;
  logic [1:0]  pia, pib;
  logic        tra, trb, pva, pvb, busya, busyb, donea, doneb;

  // Stand-in MLP: a fixed combinational function of the applied sample.
  function automatic logic [7:0] mlp_f(input logic [15:0] v, input logic [7:0] e);
    logic [7:0] m;
    m = v[15:8] * 8'd3;
    return (v[7:0] + m) ^ e;
  endfunction

  assign preda = mlp_f(va, xa);
  assign predb = mlp_f(vb, xb);

  mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .NUM_SAMPLES(NA), .SETTLE_CYCLES(ST),
                        .EPOCH_W(16), .DATA_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_values(wr_values),
    .wr_expected(wr_expected), .start(start), .train_mode(train_mode), .num_epochs(num_epochs),
    .abort(abort), .mlp_pred(preda), .mlp_values(va), .mlp_expected(xa), .mlp_training(tra),
    .pred_valid(pva), .pred_data(pda), .pred_idx(pia), .epoch_count(eca), .busy(busya),
    .done(donea));

  mlp_train_sequencer #(.INPUTS(2), .OUTPUTS(1), .NUM_SAMPLES(NB), .SETTLE_CYCLES(ST),
                        .EPOCH_W(16), .DATA_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_values(wr_values),
    .wr_expected(wr_expected), .start(start), .train_mode(train_mode), .num_epochs(num_epochs),
    .abort(abort), .mlp_pred(predb), .mlp_values(vb), .mlp_expected(xb), .mlp_training(trb),
    .pred_valid(pvb), .pred_data(pdb), .pred_idx(pib), .epoch_count(ecb), .busy(busyb),
    .done(doneb));

  // Reference sample stores
  logic [15:0] mva [NA];
  logic [7:0]  mxa [NA];
  logic [15:0] mvb [NB];
  logic [7:0]  mxb [NB];

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] qa[$], qb[$];
  int qa_cyc[$];
  int train_a, train_b, orphan_a, orphan_b, done_a, done_b, done_cyc_a, busy_seen;

  always @(negedge clk) begin
    if (pva === 1'b1) begin qa.push_back({pia, pda}); qa_cyc.push_back(cyc); end
    if (pvb === 1'b1) qb.push_back({pib, pdb});
    if (tra === 1'b1) begin train_a++; if (pva !== 1'b1) orphan_a++; end
    if (trb === 1'b1) begin train_b++; if (pvb !== 1'b1) orphan_b++; end
    if (donea === 1'b1) begin done_a++; done_cyc_a = cyc; end
    if (doneb === 1'b1) done_b++;
    if (busya === 1'b1) busy_seen++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    qa.delete(); qb.delete(); qa_cyc.delete();
    train_a = 0; train_b = 0; orphan_a = 0; orphan_b = 0;
    done_a = 0; done_b = 0; done_cyc_a = 0; busy_seen = 0;
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] v, input logic [7:0] e);
    wr_en = 1'b1; wr_addr = a; wr_values = v; wr_expected = e;
    tick();
    wr_en = 1'b0;
    if (int'(a) < NA) begin mva[a] = v; mxa[a] = e; end
    if (int'(a) < NB) begin mvb[a] = v; mxb[a] = e; end
  endtask

  task automatic run_check(input string name, input bit train, input int epochs, input bit junk);
    logic [9:0] exp;
    int per;
    clear_mon();
    start = 1'b1; train_mode = train; num_epochs = 16'(epochs);
    tick();
    start = 1'b0;
    if (junk) begin
      for (int k = 0; k < 6; k++) begin
        wr_en = 1'b1; wr_addr = 2'(k); wr_values = 16'($urandom); wr_expected = 8'($urandom);
        tick();
      end
      wr_en = 1'b0;
    end
    for (int t = 0; t < 3000 && !(done_a > 0 && done_b > 0); t++) tick();
    repeat (3) tick();
    vectors++;
    if (!(done_a > 0 && done_b > 0)) begin
      miscompares++;
      $display("FAIL %s timeout: done_a=%0d done_b=%0d required both >0", name, done_a, done_b);
    end
    vectors++;
    if (qa.size() != epochs * NA) begin
      miscompares++;
      $display("FAIL %s pred count A: got %0d want %0d", name, qa.size(), epochs * NA);
    end else begin
      for (int e = 0; e < epochs; e++)
        for (int i = 0; i < NA; i++) begin
          exp = {2'(i), mlp_f(mva[i], mxa[i])};
          vectors++;
          if (qa[e*NA+i] !== exp) begin
            miscompares++;
            $display("FAIL %s pred A[%0d]: got %h want %h", name, e*NA+i, qa[e*NA+i], exp);
          end
        end
      per = ST + (train ? 3 : 2);
      for (int k = 1; k < qa.size(); k++) begin
        vectors++;
        if (qa_cyc[k] - qa_cyc[k-1] != per) begin
          miscompares++;
          $display("FAIL %s spacing[%0d]: got %0d want %0d", name, k,
                   qa_cyc[k] - qa_cyc[k-1], per);
        end
      end
      vectors++;
      if (qa.size() > 0 && done_cyc_a != qa_cyc[qa.size()-1] + (train ? 2 : 1)) begin
        miscompares++;
        $display("FAIL %s done timing: got cyc %0d want %0d", name, done_cyc_a,
                 qa_cyc[qa.size()-1] + (train ? 2 : 1));
      end
    end
    vectors++;
    if (qb.size() != epochs * NB) begin
      miscompares++;
      $display("FAIL %s pred count B: got %0d want %0d", name, qb.size(), epochs * NB);
    end else begin
      for (int e = 0; e < epochs; e++)
        for (int i = 0; i < NB; i++) begin
          exp = {2'(i), mlp_f(mvb[i], mxb[i])};
          vectors++;
          if (qb[e*NB+i] !== exp) begin
            miscompares++;
            $display("FAIL %s pred B[%0d]: got %h want %h", name, e*NB+i, qb[e*NB+i], exp);
          end
        end
    end
    vectors++;
    if (train_a != (train ? epochs * NA : 0) || train_b != (train ? epochs * NB : 0)) begin
      miscompares++;
      $display("FAIL %s training pulses: got %0d/%0d want %0d/%0d", name, train_a, train_b,
               train ? epochs * NA : 0, train ? epochs * NB : 0);
    end
    vectors++;
    if (orphan_a != 0 || orphan_b != 0) begin
      miscompares++;
      $display("FAIL %s training without capture: got %0d/%0d want 0", name, orphan_a, orphan_b);
    end
    vectors++;
    if (done_a != 1 || done_b != 1) begin
      miscompares++;
      $display("FAIL %s done count: got %0d/%0d want 1", name, done_a, done_b);
    end
    vectors++;
    if (eca !== 16'(epochs) || ecb !== 16'(epochs)) begin
      miscompares++;
      $display("FAIL %s epoch_count: got %0d/%0d want %0d", name, eca, ecb, epochs);
    end
    vectors++;
    if (va !== mva[NA-1] || xa !== mxa[NA-1]) begin
      miscompares++;
      $display("FAIL %s retained sample: got %h/%h want %h/%h", name, va, xa,
               mva[NA-1], mxa[NA-1]);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    tick();
    vectors++;
    if ({busya, pva, donea, tra, eca, va, xa, pda, pia} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got busy=%b pv=%b done=%b tr=%b ec=%h v=%h want all 0",
               busya, pva, donea, tra, eca, va);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (busya !== 1'b0) begin
      miscompares++;
      $display("FAIL reset release busy: got %b want 0", busya);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < NA; i++) load(2'(i), 16'($urandom) | 16'h0101, 8'($urandom));
    start = 1'b1; train_mode = 1'b0; num_epochs = 16'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (va !== mva[0] || busya !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun precondition: got v=%h busy=%b want %h/1", va, busya, mva[0]);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({busya, va, xa, eca, pva, tra, donea} !== '0) begin
      miscompares++;
      $display("FAIL midrun reset outputs: got busy=%b v=%h x=%h ec=%h want 0",
               busya, va, xa, eca);
    end
    #2 rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (busya !== 1'b0 || busyb !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun busy after release: got %b/%b want 0", busya, busyb);
    end
  endtask

  task automatic test_infer_xor();
    for (int i = 0; i < NA; i++)
      load(2'(i), {(i[1] ? 8'h10 : 8'h00), (i[0] ? 8'h10 : 8'h00)},
           ((i[0] ^ i[1]) ? 8'h10 : 8'h00));
    run_check("infer_xor", 1'b0, 1, 1'b0);
  endtask

  task automatic test_train();
    run_check("train_3ep", 1'b1, 3, 1'b0);
  endtask

  task automatic test_zero_epochs();
    clear_mon();
    start = 1'b1; train_mode = 1'b1; num_epochs = 16'd0;
    tick();
    start = 1'b0;
    vectors++;
    if (donea !== 1'b1 || doneb !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_epochs done: got %b/%b want 1", donea, doneb);
    end
    repeat (10) tick();
    vectors++;
    if (busy_seen != 0 || qa.size() != 0 || done_a != 1 || eca !== 16'd0) begin
      miscompares++;
      $display("FAIL zero_epochs aftermath: busy=%0d preds=%0d done=%0d ec=%0d want 0/0/1/0",
               busy_seen, qa.size(), done_a, eca);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    clear_mon();
    start = 1'b1; abort = 1'b1; train_mode = 1'b1; num_epochs = 16'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    vectors++;
    if (busy_seen != 0 || done_a != 0) begin
      miscompares++;
      $display("FAIL start+abort: busy=%0d done=%0d want 0/0", busy_seen, done_a);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 300 && n < 6; t++) begin
      tick();
      if (pva === 1'b1) n++;
    end
    vectors++;
    if (n != 6 || tra !== 1'b1) begin
      miscompares++;
      $display("FAIL abort precondition: preds=%0d training=%b want 6/1", n, tra);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (tra !== 1'b0 || busya !== 1'b0 || busyb !== 1'b0) begin
      miscompares++;
      $display("FAIL abort state: training=%b busy=%b/%b want 0", tra, busya, busyb);
    end
    repeat (8) tick();
    vectors++;
    if (done_a != 0 || done_b != 0 || eca !== 16'd1 || train_a != 6) begin
      miscompares++;
      $display("FAIL abort aftermath: done=%0d/%0d ec=%0d train=%0d want 0/0/1/6",
               done_a, done_b, eca, train_a);
    end
  endtask

  task automatic test_store_protect();
    run_check("protect_busy_writes", 1'b0, 1, 1'b1);
    load(2'd3, 16'($urandom), 8'($urandom));
    run_check("protect_oob_addr", 1'b0, 1, 1'b0);
    run_check("protect_repeat", 1'b0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NA; i++) load(2'(i), 16'($urandom), 8'($urandom));
      run_check("random", 1'($urandom), int'($urandom_range(1, 2)), 1'b0);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_reset_midrun();
    test_infer_xor();
    test_train();
    test_zero_epochs();
    test_abort();
    test_store_protect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
